uart_tx_fifo_engine: RTL

Parametrised successor to the project's UART transmit engine. It accepts characters from the processor bus into an internal FIFO and serialises them onto `tx` with a programmable character width, parity mode and stop-bit count. Frames go out back-to-back while the FIFO holds data. It sits between the bus-side UART register decode and the `tx` pad, driven by the same `baud_count` value as the receive engine.

---
 rtl/uart_tx_fifo_engine_if.sv | 15 +
 rtl/uart_tx_fifo_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_engine_if.sv
// Write-side bus of the UART transmit engine: write strobe and data in,
// FIFO status (ready, occupancy, dropped-write pulse) out.
interface uart_tx_fifo_engine_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          wr_en;
  logic [DATA_W-1:0]             wr_data;
  logic                          txrdy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (output wr_en, wr_data, input txrdy, fifo_count, overflow);
  modport slave  (input wr_en, wr_data, output txrdy, fifo_count, overflow);
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine: write FIFO feeding a framer with programmable width, parity
// and stop bits. Defining UART_TX_BREAK_EN adds the brk input for line-break generation.
module uart_tx_fifo_engine #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BAUD_W-1:0]    baud_count,
  input  logic                 p_en,
  input  logic                 odd,
  input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  uart_tx_fifo_engine_if.slave bus,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
`ifdef UART_TX_BREAK_EN
    , BREAK, GAP
`endif
  } state_t;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd_sel);
    return (^d) ^ odd_sel;
  endfunction

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty, push, pop, overflow;
  logic [DATA_W-1:0] shreg;
  logic              par_bit, p_en_l, two_stop_l;
  logic [BAUD_W-1:0] baud_l, timer, baud_eff;
  logic [2:0]        bit_idx;
  logic              bit_up, last_bit, last_stop, tx_next, gap_load, brk_on;

`ifdef UART_TX_BREAK_EN
  assign brk_on = brk;
`else
  assign brk_on = 1'b0;
`endif

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == {CW{1'b0}});
  assign push      = bus.wr_en && (!full || pop);
  assign baud_eff  = (baud_count == {BAUD_W{1'b0}}) ? BAUD_W'(1) : baud_count;
  assign bit_up    = (timer == baud_l - BAUD_W'(1));
  assign last_bit  = (bit_idx == 3'(DATA_W - 1));
  assign last_stop = bit_up && ((state == STOP2) || ((state == STOP1) && !two_stop_l));

  // Next framer state, next line level and FIFO pop request.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    pop        = 1'b0;
    gap_load   = 1'b0;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state_next = BREAK;
          tx_next    = 1'b0;
        end else
`endif
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end else begin
          tx_next = 1'b1;
        end
      end
      START: begin
        if (bit_up) begin
          state_next = DATA;
          tx_next    = shreg[0];
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_up && !last_bit) begin
          tx_next = shreg[1];
        end else if (bit_up && p_en_l) begin
          state_next = PARITY;
          tx_next    = par_bit;
        end else if (bit_up) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (bit_up) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end else begin
          state_next = PARITY;
        end
      end
      STOP1, STOP2: begin
        // A pending break wins over the next queued character.
        if (last_stop && !empty && !brk_on) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end else if (last_stop) begin
          state_next = IDLE;
          tx_next    = 1'b1;
        end else if (bit_up) begin
          state_next = STOP2;
        end else begin
          state_next = state;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!brk) begin
          state_next = GAP;
          tx_next    = 1'b1;
          gap_load   = 1'b1;
        end else begin
          tx_next = 1'b0;
        end
      end
      GAP: begin
        if (bit_up) begin
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Framer state, line register, bit timer and per-frame latched settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      shreg      <= {DATA_W{1'b0}};
      par_bit    <= 1'b0;
      p_en_l     <= 1'b0;
      two_stop_l <= 1'b0;
      baud_l     <= BAUD_W'(1);
      timer      <= {BAUD_W{1'b0}};
      bit_idx    <= 3'd0;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      if (pop) begin
        shreg      <= mem[rd_ptr];
        par_bit    <= parity_bit(mem[rd_ptr], odd);
        p_en_l     <= p_en;
        two_stop_l <= two_stop;
        baud_l     <= baud_eff;
        timer      <= {BAUD_W{1'b0}};
        bit_idx    <= 3'd0;
      end else if (gap_load) begin
        baud_l <= baud_eff;
        timer  <= {BAUD_W{1'b0}};
      end else if (state == IDLE) begin
        timer <= {BAUD_W{1'b0}};
      end else if (bit_up) begin
        timer <= {BAUD_W{1'b0}};
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        timer <= timer + BAUD_W'(1);
      end
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy and the registered dropped-write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= bus.wr_en && !push;
    end
  end

  assign bus.txrdy      = !full;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;
  assign tx_busy        = (state != IDLE) || !empty;
endmodule
